// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect capture across imem misses, HALT freeze and IF/ID latch.
// Optional saturating performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic [1:0]  pc_src,
  input  logic        branch_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        flushed1,
  input  logic        id_en1,
  input  logic        halt,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    WAIT_REDIR = 2'd1,
    HALTED     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_PC4    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_JR     = 2'b11
  } pc_src_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4o_q, pc4o_d;
  logic        valid_q, valid_d;

  logic [31:0] pc4;
  logic        redirect;
  logic [31:0] target;

  assign pc4      = pc_q + 32'd4;
  assign imemaddr = pc_q;
  assign imemREN  = (state_q != HALTED);

  always_comb begin
    redirect = 1'b0;
    target   = pc4;
    case (pc_src_e'(pc_src))
      SRC_BRANCH: begin
        redirect = branch_sel;
        target   = branch_sel ? branch_target : pc4;
      end
      SRC_JUMP: begin
        redirect = 1'b1;
        target   = jump_target;
      end
      SRC_JR: begin
        redirect = 1'b1;
        target   = jr_target;
      end
      default: begin
        redirect = 1'b0;
        target   = pc4;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    pc4o_d  = pc4o_q;
    valid_d = valid_q;

    // IF/ID is frozen once halted; otherwise flush outranks any load.
    if (state_q != HALTED) begin
      if (flushed1) begin
        instr_d = '0;
        valid_d = 1'b0;
      end else if (id_en1 && ihit) begin
        if (state_q == FETCH) begin
          instr_d = imemload;
          pc4o_d  = pc4;
          valid_d = 1'b1;
        end else begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
    end

    case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
        end else if (pc_en) begin
          if (ihit) begin
            pc_d = target;
          end else if (redirect) begin
            pend_d  = target;
            state_d = WAIT_REDIR;
          end
        end
      end
      WAIT_REDIR: begin
        if (halt) begin
          state_d = HALTED;
        end else if (pc_en && ihit) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      pend_q  <= '0;
      instr_q <= '0;
      pc4o_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      pc4o_q  <= pc4o_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc4_out   = pc4o_q;
  assign valid_out = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_inc, bubble_inc;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  assign fetch_inc  = (state_q == FETCH) && !flushed1 && id_en1 && ihit;
  assign bubble_inc = (state_q != HALTED) &&
                      (flushed1 || (id_en1 && ihit && (state_q == WAIT_REDIR)));

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_inc && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble_inc && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter PC_INIT, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have nRST  in  1  reset, synchronous, active-low.
REQ-004 SHALL have pc_en  in  1  hazard-unit PC advance enable.
REQ-005 SHALL have pc_src  in  2  next-PC select: 00 PC4, 01 BRANCH, 10 JUMP, 11 JR.
REQ-006 SHALL have branch_sel  in  1  branch taken; qualifies pc_src=BRANCH.
REQ-007 SHALL have branch_target, jump_target, jr_target  in  32 each  redirect targets.
REQ-008 SHALL have flushed1  in  1  flush IF/ID; id_en1  in  1  IF/ID load enable.
REQ-009 SHALL have halt  in  1  HALT decoded in ID.
REQ-010 SHALL have ihit  in  1  instruction memory hit; imemload  in  32  fetched word.
REQ-011 SHALL have imemREN  out  1  fetch request; imemaddr  out  32  fetch address.
REQ-012 SHALL have instr_out  out  32, pc4_out  out  32, valid_out  out  1: IF/ID contents.
REQ-013 SHALL have fetch_cnt  out  32, bubble_cnt  out  32: performance counters.

Function
REQ-014 SHALL keep a PC register; imemaddr = PC combinationally; pc4 = PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-015 SHALL define redirect = (pc_src==JUMP) | (pc_src==JR) | (pc_src==BRANCH & branch_sel); target = jump/jr/branch_target respectively, else pc4.
REQ-016 SHALL implement states FETCH, WAIT_REDIR, HALTED.
REQ-017 FETCH: pc_en & ihit -> PC <= target (pc4 when no redirect), 1-cycle latency.
REQ-018 FETCH: pc_en & redirect & !ihit -> pend_pc <= target, go WAIT_REDIR, PC held.
REQ-019 WAIT_REDIR: PC held, imemREN=1; on ihit -> PC <= pend_pc, fetched word discarded (bubble), go FETCH.
REQ-020 WAIT_REDIR: further redirects ignored; first captured target wins.
REQ-021 pc_en=0: PC held, no redirect captured, state unchanged.
REQ-022 halt=1 (any state) -> HALTED next cycle; HALTED: imemREN=0, PC frozen, IF/ID held; exits only via reset.
REQ-023 imemREN = 1 in FETCH and WAIT_REDIR, 0 in HALTED.
REQ-024 IF/ID priority: flushed1 -> instr_out=0, valid_out=0, pc4_out held; else id_en1 & ihit & state FETCH -> instr_out<=imemload, pc4_out<=pc4, valid_out<=1; else id_en1 & ihit & WAIT_REDIR -> instr_out=0, valid_out=0; else hold.
REQ-025 flushed1 and id_en1 both 1 -> flush wins.
REQ-026 redirect and ihit same cycle in FETCH -> PC <= target directly; pend_pc unused.
REQ-027 halt coincident with redirect -> halt wins; PC not updated.

Reset
REQ-028 nRST=0 at clock edge -> PC=PC_INIT, state FETCH, pend_pc=0, instr_out=0, pc4_out=0, valid_out=0, counters 0; imemREN=1 first cycle after reset.
REQ-029 Reset during WAIT_REDIR or HALTED SHALL discard pending target and resume fetch at PC_INIT.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: fetch_cnt increments on each IF/ID valid load; bubble_cnt increments on each flush or WAIT_REDIR discard; both saturate at 32'hFFFF_FFFF.
REQ-031 Macro FETCH_PERF_CNT_EN undefined: counters not built; fetch_cnt and bubble_cnt tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, PC_INIT=0, ihit=1, pc_en=1, pc_src=PC4, id_en1=1 for 3 cycles -> imemaddr 0,4,8; valid_out=1, pc4_out 4 then 8.
REQ-033 PC=0x40, pc_src=BRANCH, branch_sel=1, branch_target=0x100, ihit=0 -> WAIT_REDIR, PC stays 0x40; ihit=1 two cycles later -> PC=0x100, valid_out=0 for that load.
REQ-034 In WAIT_REDIR apply pc_src=JUMP, jump_target=0x200 -> ignored; resume PC=0x100.
REQ-035 flushed1=1 and id_en1=1 with ihit=1 -> instr_out=0, valid_out=0; bubble_cnt +1 when FETCH_PERF_CNT_EN defined, stays 0 otherwise.
REQ-036 halt=1 at PC=0x80 -> next cycle imemREN=0, PC=0x80 held 10 cycles; nRST=0 -> PC=PC_INIT, imemREN=1.
